l2_req_arb: RTL and testbench



---
 rtl/l2_pkg.sv | 37 +++
 rtl/base_rr_arb.sv | 46 ++++
 rtl/l2_req_arb.sv | 169 ++++++++++++++++
 tb/tb_l2_req_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// l2_pkg: shared sizes, types and helpers for the L2 request arbiter.
//
// Types:
//   tag_t       - host request tag
//   sid_t       - stream pointer index
//   slot_t      - L2 line slot within a stream
//   cnt_t       - outstanding-tag counter, one bit wider than tag_t so "full" is representable
//   tag_entry_t - per-tag ownership record {sid, slot}
package l2_pkg;

    localparam int nstreams         = 4;
    localparam int addr_width       = 64;
    localparam int cache_line       = 128;
    localparam int cache_line_width = $clog2(cache_line);
    localparam int l2_ncl           = 256;
    localparam int l2_ncl_width     = $clog2(l2_ncl);
    localparam int ntags            = 32;
    localparam int tag_width        = $clog2(ntags);
    localparam int sid_width        = $clog2(nstreams);
    localparam int cnt_width        = tag_width + 1;

    typedef logic [tag_width-1:0]    tag_t;
    typedef logic [sid_width-1:0]    sid_t;
    typedef logic [l2_ncl_width-1:0] slot_t;
    typedef logic [cnt_width-1:0]    cnt_t;

    typedef struct packed {
        sid_t  sid;
        slot_t slot;
    } tag_entry_t;

    // Line slot addressed by an EA: the line-index bits just above the byte offset.
    function automatic slot_t ea_to_slot(input logic [addr_width-1:0] ea);
        return ea[cache_line_width +: l2_ncl_width];
    endfunction

endpackage

// File: rtl/base_rr_arb.sv
// base_rr_arb: combinational round-robin grant.
//
// The search starts at ptr and walks ptr, ptr+1, ... modulo width; the first
// requester found wins.
//
// Ports:
//   req     in  width      request vector
//   ptr     in  ptr_width  index with highest priority this cycle
//   gnt     out width      one-hot grant (all zero when no request)
//   gnt_idx out ptr_width  index of the granted requester
//   gnt_v   out 1          some requester was granted
module base_rr_arb #(
    parameter  int width     = 4,
    localparam int ptr_width = (width > 1) ? $clog2(width) : 1
) (
    input  logic [width-1:0]     req,
    input  logic [ptr_width-1:0] ptr,
    output logic [width-1:0]     gnt,
    output logic [ptr_width-1:0] gnt_idx,
    output logic                 gnt_v
);

    int                   idx_i;
    logic [ptr_width-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_v   = 1'b0;
        idx_i   = 0;
        idx     = '0;
        for (int i = 0; i < width; i++) begin
            idx_i = int'(ptr) + i;
            if (idx_i >= width) begin
                idx_i = idx_i - width;
            end
            idx = idx_i[ptr_width-1:0];
            if (!gnt_v && req[idx]) begin
                gnt_v      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/l2_req_arb.sv
// l2_req_arb: merges cache-line requests from the L2 stream pointers onto one
// host request port, tags them from a circular ring, and retires host
// responses back to their owning stream in issue order.
//
// Handshake: a transfer happens on a port in every cycle where valid and ready
// are both high at the clock edge; a valid source holds its payload until that
// happens. i_rsp_v has no ready and is always accepted.
//
// Ports:
//   clk, reset  clock; synchronous active-high reset
//   i_req_v/r   per-stream request valid / ready (at most one ready bit high)
//   i_req_ea    per-stream EA, stream s at [s*addr_width +: addr_width]
//   o_req_*     host request valid / ready / EA / tag (registered stage)
//   i_rsp_v/tag host response, any order
//   o_wr_v/addr URAM line write strobe and {sid, slot}, one cycle after response
//   o_rsp_v     one-hot retire pulse to the owning stream, in issue order
module l2_req_arb
    import l2_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic [nstreams-1:0]                i_req_v,
    output logic [nstreams-1:0]                i_req_r,
    input  logic [nstreams*addr_width-1:0]     i_req_ea,
    output logic                               o_req_v,
    input  logic                               o_req_r,
    output logic [addr_width-1:0]              o_req_ea,
    output logic [tag_width-1:0]               o_req_tag,
    input  logic                               i_rsp_v,
    input  logic [tag_width-1:0]               i_rsp_tag,
    output logic                               o_wr_v,
    output logic [sid_width+l2_ncl_width-1:0]  o_wr_addr,
    output logic [nstreams-1:0]                o_rsp_v
);

    logic                    o_req_v_q,   o_req_v_d;
    logic [addr_width-1:0]   o_req_ea_q,  o_req_ea_d;
    tag_t                    o_req_tag_q, o_req_tag_d;
    logic                    o_wr_v_q,    o_wr_v_d;
    tag_entry_t              o_wr_addr_q, o_wr_addr_d;
    logic [nstreams-1:0]     o_rsp_v_q,   o_rsp_v_d;
    logic [ntags-1:0]        done_q,      done_d;
    tag_t                    head_q,      head_d;
    tag_t                    tail_q,      tail_d;
    cnt_t                    cnt_q,       cnt_d;
    sid_t                    rr_ptr_q,    rr_ptr_d;
    tag_entry_t              tbl_q [ntags];
    tag_entry_t              tbl_d [ntags];

    logic [nstreams-1:0]     gnt;
    sid_t                    gnt_idx;
    logic                    gnt_v;
    logic [addr_width-1:0]   g_ea;
    logic                    load;
    logic                    retire;
    sid_t                    head_sid;
    tag_entry_t              rsp_e;

    base_rr_arb #(.width(nstreams)) u_rr (
        .req     (i_req_v),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_v   (gnt_v)
    );

    always_comb begin
        g_ea = '0;
        for (int s = 0; s < nstreams; s++) begin
            if (gnt[s]) begin
                g_ea = i_req_ea[s*addr_width +: addr_width];
            end
        end

        // Load only when the output stage is empty or draining and a tag is free.
        load     = (~o_req_v_q | o_req_r) & gnt_v & (cnt_q < cnt_t'(ntags));
        i_req_r  = load ? gnt : '0;
        // done is registered, so a response never retires in its own arrival cycle.
        retire   = (cnt_q != '0) & done_q[head_q];
        head_sid = tbl_q[head_q].sid;
        rsp_e    = tbl_q[i_rsp_tag];

        o_req_v_d   = o_req_v_q;
        o_req_ea_d  = o_req_ea_q;
        o_req_tag_d = o_req_tag_q;
        tail_d      = tail_q;
        rr_ptr_d    = rr_ptr_q;
        tbl_d       = tbl_q;
        if (load) begin
            o_req_v_d     = 1'b1;
            o_req_ea_d    = g_ea;
            o_req_tag_d   = tail_q;
            tail_d        = tail_q + tag_t'(1);
            rr_ptr_d      = (gnt_idx == sid_t'(nstreams - 1)) ? '0 : gnt_idx + sid_t'(1);
            tbl_d[tail_q] = '{sid: gnt_idx, slot: ea_to_slot(g_ea)};
        end else if (o_req_r) begin
            o_req_v_d = 1'b0;
        end

        o_wr_v_d    = i_rsp_v;
        o_wr_addr_d = rsp_e;

        o_rsp_v_d = '0;
        done_d    = done_q;
        head_d    = head_q;
        if (retire) begin
            o_rsp_v_d[head_sid] = 1'b1;
            done_d[head_q]      = 1'b0;
            head_d              = head_q + tag_t'(1);
        end
        if (i_rsp_v) begin
            done_d[i_rsp_tag] = 1'b1;
        end

        case ({load, retire})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_req_v_q   <= 1'b0;
            o_req_ea_q  <= '0;
            o_req_tag_q <= '0;
            o_wr_v_q    <= 1'b0;
            o_wr_addr_q <= '0;
            o_rsp_v_q   <= '0;
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
        end else begin
            o_req_v_q   <= o_req_v_d;
            o_req_ea_q  <= o_req_ea_d;
            o_req_tag_q <= o_req_tag_d;
            o_wr_v_q    <= o_wr_v_d;
            o_wr_addr_q <= o_wr_addr_d;
            o_rsp_v_q   <= o_rsp_v_d;
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Ownership tables hold no meaning until written by a load, so no reset.
    always_ff @(posedge clk) begin
        tbl_q <= tbl_d;
    end

    assign o_req_v   = o_req_v_q;
    assign o_req_ea  = o_req_ea_q;
    assign o_req_tag = o_req_tag_q;
    assign o_wr_v    = o_wr_v_q;
    assign o_wr_addr = o_wr_addr_q;
    assign o_rsp_v   = o_rsp_v_q;

    // A response must name an outstanding tag that has not already answered.
    tag_t rsp_age;
    assign rsp_age = i_rsp_tag - head_q;

    a_rsp_legal : assert property (@(posedge clk) disable iff (reset)
        i_rsp_v |-> ((cnt_t'(rsp_age) < cnt_q) && !done_q[i_rsp_tag]));

endmodule

// File: tb/tb_l2_req_arb.sv
module tb_l2_req_arb;
    import l2_pkg::*;

    logic                              clk;
    logic                              reset;
    logic [nstreams-1:0]               i_req_v;
    logic [nstreams-1:0]               i_req_r;
    logic [nstreams*addr_width-1:0]    i_req_ea;
    logic                              o_req_v;
    logic                              o_req_r;
    logic [addr_width-1:0]             o_req_ea;
    logic [tag_width-1:0]              o_req_tag;
    logic                              i_rsp_v;
    logic [tag_width-1:0]              i_rsp_tag;
    logic                              o_wr_v;
    logic [sid_width+l2_ncl_width-1:0] o_wr_addr;
    logic [nstreams-1:0]               o_rsp_v;

    l2_req_arb dut (
        .clk       (clk),
        .reset     (reset),
        .i_req_v   (i_req_v),
        .i_req_r   (i_req_r),
        .i_req_ea  (i_req_ea),
        .o_req_v   (o_req_v),
        .o_req_r   (o_req_r),
        .o_req_ea  (o_req_ea),
        .o_req_tag (o_req_tag),
        .i_rsp_v   (i_rsp_v),
        .i_rsp_tag (i_rsp_tag),
        .o_wr_v    (o_wr_v),
        .o_wr_addr (o_wr_addr),
        .o_rsp_v   (o_rsp_v)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [addr_width+tag_width-1:0]    exp_req_q[$];
    logic [sid_width+l2_ncl_width-1:0]  exp_wr_q[$];
    logic [nstreams-1:0]                exp_rsp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected item per presented DUT output.
    always @(negedge clk) begin
        logic [addr_width+tag_width-1:0] er;
        if (!reset) begin
            if (o_req_v && o_req_r) begin
                check("req_expected", 64'(exp_req_q.size() != 0), 64'd1);
                if (exp_req_q.size() != 0) begin
                    er = exp_req_q.pop_front();
                    check("req_ea", o_req_ea, er[tag_width +: addr_width]);
                    check("req_tag", 64'(o_req_tag), 64'(er[tag_width-1:0]));
                end
            end
            if (o_wr_v) begin
                check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) check("wr_addr", 64'(o_wr_addr), 64'(exp_wr_q.pop_front()));
            end
            if (o_rsp_v != '0) begin
                check("rsp_expected", 64'(exp_rsp_q.size() != 0), 64'd1);
                if (exp_rsp_q.size() != 0) check("rsp_v", 64'(o_rsp_v), 64'(exp_rsp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ea(input int s, input logic [addr_width-1:0] ea);
        i_req_ea[s*addr_width +: addr_width] = ea;
    endtask

    task automatic drain_check();
        repeat (4) step();
        check("drain_req", 64'(exp_req_q.size()), 64'd0);
        check("drain_wr", 64'(exp_wr_q.size()), 64'd0);
        check("drain_rsp", 64'(exp_rsp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        i_req_v = '0;
        i_rsp_v = 1'b0;
        o_req_r = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_o_req_v", 64'(o_req_v), 64'd0);
        check("rst_o_wr_v", 64'(o_wr_v), 64'd0);
        check("rst_o_rsp_v", 64'(o_rsp_v), 64'd0);
        check("rst_i_req_r", 64'(i_req_r), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Holds i_req_v[s] until granted (bounded), then drops it after the accepting edge.
    task automatic wait_grant(input int s);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!i_req_r[s] && k < 100);
        check("grant_seen", 64'(i_req_r[s]), 64'd1);
        @(posedge clk);
        #1;
        i_req_v[s] = 1'b0;
    endtask

    task automatic issue_one(input int s, input logic [addr_width-1:0] ea, input int tag);
        set_ea(s, ea);
        i_req_v[s] = 1'b1;
        exp_req_q.push_back({ea, tag_t'(tag)});
        wait_grant(s);
    endtask

    task automatic send_rsp(input int tag);
        i_rsp_v   = 1'b1;
        i_rsp_tag = tag_t'(tag);
        step();
        i_rsp_v   = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset     = 1'b1;
        i_req_v   = '0;
        i_req_ea  = '0;
        o_req_r   = 1'b1;
        i_rsp_v   = 1'b0;
        i_rsp_tag = '0;

        // Single stream: EA 0x1000 -> tag 0, slot 0x20, stream 0.
        do_reset();
        issue_one(0, 64'h1000, 0);
        check("t1_req_latency", 64'(o_req_v), 64'd1);
        exp_wr_q.push_back(10'h020);
        exp_rsp_q.push_back(4'b0001);
        send_rsp(0);
        check("t1_wr_latency", 64'(o_wr_v), 64'd1);
        check("t1_rsp_not_early", 64'(o_rsp_v), 64'd0);
        step();
        check("t1_rsp_latency", 64'(o_rsp_v), 64'b0001);
        drain_check();

        // Fairness: all four streams valid -> grants 0,1,2,3,0,1,2,3, tags 0..7.
        do_reset();
        for (int s = 0; s < nstreams; s++) set_ea(s, 64'h2000 + 64'(s) * 64'h80);
        for (int i = 0; i < 8; i++) exp_req_q.push_back({64'h2000 + 64'(i % 4) * 64'h80, tag_t'(i)});
        i_req_v = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_grant", 64'(i_req_r), 64'(4'b0001 << (i % 4)));
            @(posedge clk);
            #1;
        end
        i_req_v = '0;
        drain_check();

        // Out-of-order: tags 0,1,2 -> streams 1,2,1; responses 2,0,1.
        do_reset();
        issue_one(1, 64'h0080, 0);
        issue_one(2, 64'h3100, 1);
        issue_one(1, 64'h7F80, 2);
        exp_wr_q.push_back(10'h1FF);
        exp_wr_q.push_back(10'h101);
        exp_wr_q.push_back(10'h262);
        exp_rsp_q.push_back(4'b0010);
        exp_rsp_q.push_back(4'b0100);
        exp_rsp_q.push_back(4'b0010);
        send_rsp(2);
        send_rsp(0);
        send_rsp(1);
        drain_check();

        // Full ring: 32 outstanding, 33rd stalls until tag 0 retires, then reuses tag 0.
        do_reset();
        for (int i = 0; i < ntags; i++) issue_one(0, 64'(i) << 7, i);
        set_ea(0, 64'h5000);
        i_req_v[0] = 1'b1;
        exp_req_q.push_back({64'h5000, tag_t'(0)});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_full_stall", 64'(i_req_r), 64'd0);
            @(posedge clk);
            #1;
        end
        exp_wr_q.push_back(10'h000);
        exp_rsp_q.push_back(4'b0001);
        send_rsp(0);
        wait_grant(0);
        check("t4_realloc_tag", 64'(o_req_tag), 64'd0);
        drain_check();

        // Backpressure: stage holds, no grants, round-robin pointer frozen.
        do_reset();
        o_req_r = 1'b0;
        set_ea(2, 64'h8000);
        set_ea(3, 64'h8080);
        set_ea(0, 64'h8100);
        exp_req_q.push_back({64'h8000, tag_t'(0)});
        exp_req_q.push_back({64'h8080, tag_t'(1)});
        exp_req_q.push_back({64'h8100, tag_t'(2)});
        i_req_v = 4'b0100;
        @(negedge clk);
        check("t5_first_grant", 64'(i_req_r), 64'b0100);
        step();
        i_req_v = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_no_grant", 64'(i_req_r), 64'd0);
            check("t5_hold_v", 64'(o_req_v), 64'd1);
            check("t5_hold_ea", o_req_ea, 64'h8000);
            check("t5_hold_tag", 64'(o_req_tag), 64'd0);
            @(posedge clk);
            #1;
        end
        o_req_r = 1'b1;
        @(negedge clk);
        check("t5_resume_grant3", 64'(i_req_r), 64'b1000);
        step();
        i_req_v[3] = 1'b0;
        @(negedge clk);
        check("t5_resume_grant0", 64'(i_req_r), 64'b0001);
        step();
        i_req_v[0] = 1'b0;
        drain_check();

        // Reset mid-operation with 10 tags outstanding and a stalled request.
        do_reset();
        for (int i = 0; i < 10; i++) issue_one(1, 64'h40000 + 64'(i) * 64'h80, i);
        step();
        o_req_r = 1'b0;
        set_ea(0, 64'hDEAD0000);
        i_req_v[0] = 1'b1;
        step();
        check("t6_stalled_v", 64'(o_req_v), 64'd1);
        reset     = 1'b1;
        i_req_v   = '0;
        i_rsp_v   = 1'b1;
        i_rsp_tag = 5'd3;
        step();
        @(negedge clk);
        check("t6_rst_o_req_v", 64'(o_req_v), 64'd0);
        check("t6_rst_o_wr_v", 64'(o_wr_v), 64'd0);
        check("t6_rst_o_rsp_v", 64'(o_rsp_v), 64'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        i_rsp_v = 1'b0;
        o_req_r = 1'b1;
        issue_one(2, 64'h12345680, 0);
        check("t6_restart_tag", 64'(o_req_tag), 64'd0);
        drain_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
